live_value_table: RTL and testbench

//  Live value table (LVT) for the multi-port key/value memory. Sits directly downstream of the
//  per-engine port registers: it consumes their registered wen/ren/addr outputs, one port per

---
 rtl/live_value_table_if.sv | 24 ++
 rtl/live_value_table.sv | 84 ++++++++
 tb/tb_live_value_table.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/live_value_table_if.sv
// rtl/live_value_table_if.sv - per-engine port bundle between the port registers and the live value table
interface live_value_table_if #(
    parameter int index_width        = 8,
    parameter int processing_engines = 4,
    parameter int id_width           = 2
);
    logic [processing_engines-1:0]             wen_in;
    logic [processing_engines-1:0]             ren_in;
    logic [processing_engines*index_width-1:0] addr_in;
    logic [processing_engines*id_width-1:0]    rd_sel_out;
    logic [processing_engines-1:0]             rd_valid_out;
    logic                                      conflict_out;
    logic [15:0]                               conflict_cnt;

    modport master (
        output wen_in, ren_in, addr_in,
        input  rd_sel_out, rd_valid_out, conflict_out, conflict_cnt
    );

    modport slave (
        input  wen_in, ren_in, addr_in,
        output rd_sel_out, rd_valid_out, conflict_out, conflict_cnt
    );
endinterface

// File: rtl/live_value_table.sv
// rtl/live_value_table.sv - last-writer engine id per address; LVT_WR_BYPASS_EN forwards same-cycle writes to reads
module live_value_table #(
    parameter int index_width        = 8,
    parameter int processing_engines = 4,
    parameter int id_width           = 2
) (
    input  logic             clk,
    input  logic             reset,
    live_value_table_if.slave lvt
);
    localparam int depth = 2 ** index_width;

    logic [depth-1:0][id_width-1:0]             table_q, table_d;
    logic [processing_engines*id_width-1:0]     rd_sel_q, rd_sel_d;
    logic [processing_engines-1:0]              rd_valid_q, rd_valid_d;
    logic                                       conflict_q, conflict_d;
    logic [15:0]                                conflict_cnt_q, conflict_cnt_d;
    logic [id_width-1:0]                        sel_tmp;

    always_comb begin
        table_d        = table_q;
        conflict_d     = 1'b0;
        conflict_cnt_d = conflict_cnt_q;
        rd_sel_d       = rd_sel_q;
        rd_valid_d     = lvt.ren_in;
        sel_tmp        = '0;

        // Ascending port order lets the highest-index writer win a collision.
        for (int p = 0; p < processing_engines; p++) begin
            if (lvt.wen_in[p]) begin
                table_d[lvt.addr_in[p*index_width +: index_width]] = id_width'(p);
            end
        end

        for (int i = 0; i < processing_engines; i++) begin
            for (int j = i + 1; j < processing_engines; j++) begin
                if (lvt.wen_in[i] && lvt.wen_in[j] &&
                    lvt.addr_in[i*index_width +: index_width] == lvt.addr_in[j*index_width +: index_width]) begin
                    conflict_d = 1'b1;
                end
            end
        end

        if (conflict_d && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end

        for (int p = 0; p < processing_engines; p++) begin
            if (lvt.ren_in[p]) begin
                sel_tmp = table_q[lvt.addr_in[p*index_width +: index_width]];
`ifdef LVT_WR_BYPASS_EN
                for (int w = 0; w < processing_engines; w++) begin
                    if (lvt.wen_in[w] &&
                        lvt.addr_in[w*index_width +: index_width] == lvt.addr_in[p*index_width +: index_width]) begin
                        sel_tmp = id_width'(w);
                    end
                end
`endif
                rd_sel_d[p*id_width +: id_width] = sel_tmp;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            table_q        <= '0;
            rd_sel_q       <= '0;
            rd_valid_q     <= '0;
            conflict_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            table_q        <= table_d;
            rd_sel_q       <= rd_sel_d;
            rd_valid_q     <= rd_valid_d;
            conflict_q     <= conflict_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign lvt.rd_sel_out   = rd_sel_q;
    assign lvt.rd_valid_out = rd_valid_q;
    assign lvt.conflict_out = conflict_q;
    assign lvt.conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_live_value_table.sv
// tb/tb_live_value_table.sv - scoreboard bench for live_value_table
module tb_live_value_table;
    localparam int IW = 8;
    localparam int P  = 4;
    localparam int ID = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    live_value_table_if #(.index_width(IW), .processing_engines(P), .id_width(ID)) bus ();

    live_value_table #(.index_width(IW), .processing_engines(P), .id_width(ID)) dut (
        .clk   (clk),
        .reset (reset),
        .lvt   (bus)
    );

    typedef struct {
        int            port;
        logic [ID-1:0] sel;
    } rd_exp_t;

    rd_exp_t       sb_q[$];
    logic [ID-1:0] model_tbl [256];
    logic [15:0]   model_cnt;
    int            vec_cnt        = 0;
    int            miscompare_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_tbl[i] = '0;
        model_cnt = '0;
        sb_q.delete();
    endtask

    task automatic step(input logic [P-1:0] wen, input logic [P-1:0] ren,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0]    a [P];
        logic          conf;
        logic [ID-1:0] s;
        rd_exp_t       e;
        a = '{a0, a1, a2, a3};
        for (int p = 0; p < P; p++) begin
            if (ren[p]) begin
                s = model_tbl[a[p]];
`ifdef LVT_WR_BYPASS_EN
                for (int w = 0; w < P; w++) if (wen[w] && a[w] == a[p]) s = ID'(w);
`endif
                e.port = p;
                e.sel  = s;
                sb_q.push_back(e);
            end
        end
        conf = 1'b0;
        for (int i = 0; i < P; i++)
            for (int j = i + 1; j < P; j++)
                if (wen[i] && wen[j] && a[i] == a[j]) conf = 1'b1;
        for (int p = 0; p < P; p++) if (wen[p]) model_tbl[a[p]] = ID'(p);
        if (conf && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;

        bus.wen_in  = wen;
        bus.ren_in  = ren;
        bus.addr_in = {a3, a2, a1, a0};
        @(posedge clk);
        #1;
        check_val("rd_valid", 32'(bus.rd_valid_out), 32'(ren));
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val($sformatf("rd_sel_p%0d", e.port), 32'(bus.rd_sel_out[e.port*ID +: ID]), 32'(e.sel));
        end
        check_val("conflict_out", 32'(bus.conflict_out), 32'(conf));
        check_val("conflict_cnt", 32'(bus.conflict_cnt), 32'(model_cnt));
        bus.wen_in = '0;
        bus.ren_in = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        bus.wen_in  = '0;
        bus.ren_in  = '0;
        bus.addr_in = '0;

        // Reset held with random traffic
        for (int i = 0; i < 6; i++) begin
            bus.wen_in  = 4'($urandom);
            bus.ren_in  = 4'($urandom);
            bus.addr_in = 32'($urandom);
            @(posedge clk);
        end
        bus.wen_in = '0;
        bus.ren_in = '0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_rd_sel", 32'(bus.rd_sel_out), 32'h0);
        check_val("rst_rd_valid", 32'(bus.rd_valid_out), 32'h0);
        check_val("rst_conflict", 32'(bus.conflict_out), 32'h0);
        check_val("rst_cnt", 32'(bus.conflict_cnt), 32'h0);
        for (int i = 0; i < 256; i++) step(4'b0000, 4'b1001, 8'(i), 8'h0, 8'h0, 8'(255 - i));

        // Write then readback, latency and hold
        step(4'b0100, 4'b0000, 8'h00, 8'h00, 8'h10, 8'h00);
        step(4'b0000, 4'b0001, 8'h10, 8'h00, 8'h00, 8'h00);
        check_val("wr_rd_sel", 32'(bus.rd_sel_out[1:0]), 32'd2);
        check_val("wr_rd_valid", 32'(bus.rd_valid_out[0]), 32'd1);
        step(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        check_val("hold_rd_sel", 32'(bus.rd_sel_out[1:0]), 32'd2);

        // Collisions
        step(4'b1010, 4'b0000, 8'h00, 8'h20, 8'h00, 8'h20);
        check_val("coll_pulse", 32'(bus.conflict_out), 32'd1);
        check_val("coll_cnt", 32'(bus.conflict_cnt), 32'd1);
        step(4'b0000, 4'b0001, 8'h20, 8'h00, 8'h00, 8'h00);
        check_val("coll_winner", 32'(bus.rd_sel_out[1:0]), 32'd3);
        step(4'b1111, 4'b0000, 8'h40, 8'h41, 8'h42, 8'h43);
        step(4'b1111, 4'b0000, 8'h50, 8'h50, 8'h51, 8'h51);
        check_val("two_groups_cnt", 32'(bus.conflict_cnt), 32'd2);

        // Same-cycle read/write
        step(4'b0010, 4'b0000, 8'h00, 8'h30, 8'h00, 8'h00);
        step(4'b0100, 4'b0001, 8'h30, 8'h00, 8'h30, 8'h00);
`ifdef LVT_WR_BYPASS_EN
        check_val("raw_sel", 32'(bus.rd_sel_out[1:0]), 32'd2);
`else
        check_val("raw_sel", 32'(bus.rd_sel_out[1:0]), 32'd1);
`endif
        step(4'b0000, 4'b0001, 8'h30, 8'h00, 8'h00, 8'h00);
        check_val("raw_after", 32'(bus.rd_sel_out[1:0]), 32'd2);

        // Random traffic over a narrow address window
        for (int i = 0; i < 300; i++)
            step(4'($urandom), 4'($urandom), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));

        // Counter saturation
        for (int i = 0; i < 65536; i++) step(4'b0011, 4'b0000, 8'h60, 8'h60, 8'h00, 8'h00);
        check_val("sat_cnt", 32'(bus.conflict_cnt), 32'hFFFF);
        step(4'b1100, 4'b0000, 8'h00, 8'h00, 8'h61, 8'h61);
        check_val("sat_hold", 32'(bus.conflict_cnt), 32'hFFFF);

        // Asynchronous reset between ren and its capture edge
        step(4'b1000, 4'b0001, 8'h10, 8'h00, 8'h00, 8'h70);
        bus.ren_in  = 4'b0001;
        bus.addr_in = {8'h00, 8'h00, 8'h00, 8'h70};
        #4;
        reset = 1'b0;
        #1;
        check_val("arst_valid", 32'(bus.rd_valid_out), 32'h0);
        check_val("arst_sel", 32'(bus.rd_sel_out), 32'h0);
        check_val("arst_cnt", 32'(bus.conflict_cnt), 32'h0);
        bus.ren_in = '0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        step(4'b0000, 4'b0001, 8'h70, 8'h00, 8'h00, 8'h00);
        step(4'b0000, 4'b0001, 8'h10, 8'h00, 8'h00, 8'h00);
        check_val("arst_tbl_cleared", 32'(bus.rd_sel_out[1:0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end
endmodule
